hififo_tpc_writer: RTL and testbench

//  To-PC (FPGA->host) direction of HIFIFO. Drains 64-bit words from a user stream,

---
 rtl/hififo_pkg.sv | 18 +
 rtl/block_ram.sv | 30 +++
 rtl/hififo_desc_queue.sv | 79 +++++++
 rtl/hififo_tpc_writer.sv | 169 ++++++++++++++++
 tb/tb_hififo_tpc_writer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hififo_pkg.sv
// Shared types and constants for the HIFIFO to-PC writer: FSM encoding,
// burst/page geometry and status word bit positions.
package hififo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } tpc_state_e;

    localparam int BURST_BYTES     = 128;
    localparam int PAGE_BYTES      = 4096;
    localparam int BURSTS_PER_PAGE = PAGE_BYTES / BURST_BYTES;
    localparam int PAGE_ADDR_W     = 52;
    localparam int STATUS_OVF      = 31;
    localparam int STATUS_QLO      = 27;

endpackage

// File: rtl/block_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Contents are not reset; readers must only address words already written.
module block_ram #(
    parameter int DBITS = 64,
    parameter int ABITS = 6
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [DBITS-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ABITS-1:0] rd_addr,
    output logic [DBITS-1:0] rd_data
);

    logic [DBITS-1:0] mem [2**ABITS];
    logic [DBITS-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/hififo_desc_queue.sv
// Small FIFO of 4 KiB host page addresses (bits [63:12]) with occupancy count
// and a sticky overflow flag raised when a push arrives while full.
module hififo_desc_queue
    import hififo_pkg::*;
#(
    parameter int DESC_LOG2 = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [PAGE_ADDR_W-1:0] push_data,
    input  logic                   pop,
    output logic [PAGE_ADDR_W-1:0] head,
    output logic [DESC_LOG2:0]     count,
    output logic                   empty,
    output logic                   overflow
);

    localparam logic [DESC_LOG2:0] DEPTH = (DESC_LOG2+1)'(2**DESC_LOG2);
    localparam logic [DESC_LOG2:0] CNT_ONE = 1;
    localparam logic [DESC_LOG2-1:0] PTR_ONE = 1;

    logic [PAGE_ADDR_W-1:0] mem [2**DESC_LOG2];
    logic [DESC_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DESC_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DESC_LOG2:0]     count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   push_ok, pop_ok;

    // A push into a full queue is dropped even if a pop happens the same cycle.
    always_comb begin
        push_ok  = push && (count_q != DEPTH);
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head     = mem[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign overflow = ovf_q;

endmodule

// File: rtl/hififo_tpc_writer.sv
// FPGA->host writer: stages user words, then issues 128-byte memory-write
// requests into host pages taken from a descriptor queue.
module hififo_tpc_writer
    import hififo_pkg::*;
#(
    parameter int BURST_LOG2 = 4,
    parameter int BUF_ABITS  = 6,
    parameter int DESC_LOG2  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        desc_wvalid,
    input  logic [63:0] desc_wdata,
    output logic [31:0] status,
    output logic        interrupt,
    input  logic [63:0] fifo_data,
    input  logic        fifo_valid,
    output logic        fifo_ready,
    output logic        wr_valid,
    output logic [63:0] wr_addr,
    input  logic        wr_ready,
    input  logic        wr_data_read,
    output logic [63:0] wr_data
);

    localparam int PW     = BUF_ABITS + 1;
    localparam int BYTE_W = BURST_LOG2 + 3;
    localparam int OFF_W  = 12 - BYTE_W;

    localparam logic [PW-1:0]         BUF_DEPTH  = PW'(2**BUF_ABITS);
    localparam logic [PW-1:0]         BURST_FILL = PW'(2**BURST_LOG2);
    localparam logic [PW-1:0]         PTR_ONE    = 1;
    localparam logic [OFF_W-1:0]      OFF_ONE    = 1;
    localparam logic [BURST_LOG2-1:0] CNT_ONE    = 1;

    tpc_state_e             state_q, state_d;
    logic [PW-1:0]          p_write_q, p_write_d;
    logic [PW-1:0]          p_read_q, p_read_d;
    logic [OFF_W-1:0]       offset_q, offset_d;
    logic [BURST_LOG2-1:0]  rd_cnt_q, rd_cnt_d;
    logic [26:0]            bursts_done_q, bursts_done_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [63:0]            wr_addr_q, wr_addr_d;
    logic                   interrupt_q, interrupt_d;

    logic [PW-1:0]          fill;
    logic                   push_word;
    logic                   rd_en;
    logic                   q_pop;
    logic [PAGE_ADDR_W-1:0] q_head;
    logic [DESC_LOG2:0]     q_count;
    logic                   q_empty;
    logic                   q_ovf;
    logic                   unused_desc_low;

    assign unused_desc_low = ^desc_wdata[11:0];

    // Ready is forced low while reset is held so nothing is accepted then.
    assign fill       = p_write_q - p_read_q;
    assign fifo_ready = reset && (fill < BUF_DEPTH);
    assign push_word  = fifo_valid && fifo_ready;
    assign p_write_d  = p_write_q + (push_word ? PTR_ONE : '0);

    always_comb begin
        state_d       = state_q;
        p_read_d      = p_read_q;
        offset_d      = offset_q;
        rd_cnt_d      = rd_cnt_q;
        bursts_done_d = bursts_done_q;
        wr_valid_d    = wr_valid_q;
        wr_addr_d     = wr_addr_q;
        interrupt_d   = 1'b0;
        rd_en         = 1'b0;
        q_pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((fill >= BURST_FILL) && !q_empty) begin
                    state_d    = ST_REQ;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = {q_head, offset_q, {BYTE_W{1'b0}}};
                end
            end
            ST_REQ: begin
                if (wr_ready) begin
                    state_d    = ST_DATA;
                    wr_valid_d = 1'b0;
                    rd_cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (wr_data_read) begin
                    rd_en    = 1'b1;
                    p_read_d = p_read_q + PTR_ONE;
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                    // Last word of the burst: advance within the page, retire it when full.
                    if (&rd_cnt_q) begin
                        state_d       = ST_IDLE;
                        bursts_done_d = bursts_done_q + 27'd1;
                        offset_d      = offset_q + OFF_ONE;
                        if (&offset_q) begin
                            q_pop       = 1'b1;
                            interrupt_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            p_write_q     <= '0;
            p_read_q      <= '0;
            offset_q      <= '0;
            rd_cnt_q      <= '0;
            bursts_done_q <= '0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            interrupt_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_write_q     <= p_write_d;
            p_read_q      <= p_read_d;
            offset_q      <= offset_d;
            rd_cnt_q      <= rd_cnt_d;
            bursts_done_q <= bursts_done_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            interrupt_q   <= interrupt_d;
        end
    end

    block_ram #(
        .DBITS (64),
        .ABITS (BUF_ABITS)
    ) u_stage (
        .clock   (clock),
        .wr_en   (push_word),
        .wr_addr (p_write_q[BUF_ABITS-1:0]),
        .wr_data (fifo_data),
        .rd_en   (rd_en),
        .rd_addr (p_read_q[BUF_ABITS-1:0]),
        .rd_data (wr_data)
    );

    hififo_desc_queue #(
        .DESC_LOG2 (DESC_LOG2)
    ) u_desc (
        .clock     (clock),
        .reset     (reset),
        .push      (desc_wvalid),
        .push_data (desc_wdata[63:12]),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .overflow  (q_ovf)
    );

    assign status    = {q_ovf, 4'(q_count), bursts_done_q};
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign interrupt = interrupt_q;

endmodule

// File: tb/tb_hififo_tpc_writer.sv
// Directed bench for hififo_tpc_writer: a user stream feeder and a TX engine
// model run concurrently; all expected values are computed from the vectors.
module tb_hififo_tpc_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        desc_wvalid = 1'b0;
    logic [63:0] desc_wdata = '0;
    logic [31:0] status;
    logic        interrupt;
    logic [63:0] fifo_data = '0;
    logic        fifo_valid = 1'b0;
    logic        fifo_ready;
    logic        wr_valid;
    logic [63:0] wr_addr;
    logic        wr_ready = 1'b0;
    logic        wr_data_read = 1'b0;
    logic [63:0] wr_data;

    int total = 0;
    int bad = 0;
    int irq_cnt = 0;

    hififo_tpc_writer dut (
        .clock        (clock),
        .reset        (reset),
        .desc_wvalid  (desc_wvalid),
        .desc_wdata   (desc_wdata),
        .status       (status),
        .interrupt    (interrupt),
        .fifo_data    (fifo_data),
        .fifo_valid   (fifo_valid),
        .fifo_ready   (fifo_ready),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_ready     (wr_ready),
        .wr_data_read (wr_data_read),
        .wr_data      (wr_data)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (interrupt === 1'b1) irq_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        desc_wvalid = 1'b0;
        fifo_valid = 1'b0;
        wr_ready = 1'b0;
        wr_data_read = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        irq_cnt = 0;
    endtask

    task automatic push_desc(input logic [63:0] v);
        desc_wdata = v;
        desc_wvalid = 1'b1;
        @(negedge clock);
        desc_wvalid = 1'b0;
    endtask

    // Presents base+i for i in 0..n-1; ready is stable from negedge to posedge.
    task automatic feed(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            fifo_data = base + 64'(i);
            fifo_valid = 1'b1;
            w = 0;
            while (!fifo_ready && w < 3000) begin
                @(negedge clock);
                w++;
            end
            if (!fifo_ready) begin
                chk("feed_timeout", 64'(i), 64'(n));
                fifo_valid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        fifo_valid = 1'b0;
    endtask

    task automatic tx_burst(input logic [63:0] exp_addr, input logic [63:0] exp_base,
                            input bit push_last, input logic [63:0] push_val);
        int w;
        w = 0;
        while (!wr_valid && w < 3000) begin
            @(negedge clock);
            w++;
        end
        if (!wr_valid) begin
            chk("req_timeout", 64'(wr_valid), 64'd1);
            return;
        end
        chk("wr_addr", wr_addr, exp_addr);
        wr_ready = 1'b1;
        @(negedge clock);
        wr_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_data_read = 1'b1;
            if (push_last && i == 15) begin
                desc_wdata = push_val;
                desc_wvalid = 1'b1;
            end
            @(negedge clock);
            chk("wr_data", wr_data, exp_base + 64'(i));
        end
        wr_data_read = 1'b0;
        desc_wvalid = 1'b0;
    endtask

    initial begin
        // Reset state, checked while reset is held
        #1;
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_wr_addr", wr_addr, 64'd0);
        chk("rst_irq", 64'(interrupt), 64'd0);
        chk("rst_ready", 64'(fifo_ready), 64'd0);
        do_reset();
        chk("ready_after_rst", 64'(fifo_ready), 64'd1);

        // 1: one page, 512 words, 32 requests; low address bits ignored
        push_desc(64'h1_0000_0ABC);
        fork
            feed(64'd0, 512);
            for (int b = 0; b < 32; b++)
                tx_burst(64'h1_0000_0000 + 64'(b) * 64'h80, 64'(b) * 64'd16, 1'b0, 64'd0);
        join
        @(negedge clock);
        chk("t1_irq", 64'(irq_cnt), 64'd1);
        chk("t1_bursts", 64'(status[26:0]), 64'd32);
        chk("t1_queued", 64'(status[30:27]), 64'd0);

        // 2: fill buffer with no descriptor, then supply one
        do_reset();
        feed(64'h2000, 64);
        chk("t2_full_ready", 64'(fifo_ready), 64'd0);
        begin
            int seen = 0;
            repeat (20) begin
                @(negedge clock);
                if (wr_valid) seen++;
            end
            chk("t2_no_req", 64'(seen), 64'd0);
        end
        push_desc(64'h2_0000_0000);
        for (int b = 0; b < 4; b++)
            tx_burst(64'h2_0000_0000 + 64'(b) * 64'h80, 64'h2000 + 64'(b) * 64'd16, 1'b0, 64'd0);
        @(negedge clock);
        chk("t2_ready_back", 64'(fifo_ready), 64'd1);
        chk("t2_bursts", 64'(status[26:0]), 64'd4);

        // 3: nine pushes into an eight-entry queue
        do_reset();
        for (int k = 0; k < 9; k++)
            push_desc(64'h3_0000_0000 + 64'(k) * 64'h1000);
        chk("t3_ovf", 64'(status[31]), 64'd1);
        chk("t3_queued", 64'(status[30:27]), 64'd8);
        fork
            feed(64'h3000, 16);
            tx_burst(64'h3_0000_0000, 64'h3000, 1'b0, 64'd0);
        join

        // 4: request held off by wr_ready, stray read pulses ignored
        do_reset();
        push_desc(64'h4_0000_0000);
        feed(64'h4000, 16);
        begin
            int w = 0;
            int stable = 0;
            while (!wr_valid && w < 100) begin
                @(negedge clock);
                w++;
            end
            for (int c = 0; c < 20; c++) begin
                wr_data_read = c[0];
                @(negedge clock);
                if (wr_valid === 1'b1 && wr_addr === 64'h4_0000_0000) stable++;
            end
            wr_data_read = 1'b0;
            chk("t4_hold", 64'(stable), 64'd20);
        end
        tx_burst(64'h4_0000_0000, 64'h4000, 1'b0, 64'd0);

        // 5: two pages, 1024 words, descriptor push during the pop cycle
        do_reset();
        push_desc(64'h5_0000_0000);
        push_desc(64'h6_0000_0000);
        fork
            feed(64'h10000, 1024);
            begin
                for (int b = 0; b < 32; b++)
                    tx_burst(64'h5_0000_0000 + 64'(b) * 64'h80, 64'h10000 + 64'(b) * 64'd16,
                             b == 31, 64'h7_7000_0000);
                chk("t5_queued_mid", 64'(status[30:27]), 64'd2);
                for (int b = 32; b < 64; b++)
                    tx_burst(64'h6_0000_0000 + 64'(b - 32) * 64'h80,
                             64'h10000 + 64'(b) * 64'd16, 1'b0, 64'd0);
            end
        join
        @(negedge clock);
        chk("t5_irq", 64'(irq_cnt), 64'd2);
        chk("t5_queued_end", 64'(status[30:27]), 64'd1);
        chk("t5_bursts", 64'(status[26:0]), 64'd64);

        // 6: reset in the middle of a burst
        do_reset();
        push_desc(64'h7_0000_0000);
        feed(64'h7000, 16);
        begin
            int w = 0;
            while (!wr_valid && w < 100) begin
                @(negedge clock);
                w++;
            end
            chk("t6_addr", wr_addr, 64'h7_0000_0000);
            wr_ready = 1'b1;
            @(negedge clock);
            wr_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                wr_data_read = 1'b1;
                @(negedge clock);
                chk("t6_data", wr_data, 64'h7000 + 64'(i));
            end
            #1 reset = 1'b0;
            #1;
            chk("t6_wr_valid", 64'(wr_valid), 64'd0);
            chk("t6_wr_addr", wr_addr, 64'd0);
            chk("t6_status", 64'(status), 64'd0);
            chk("t6_irq", 64'(interrupt), 64'd0);
            chk("t6_ready", 64'(fifo_ready), 64'd0);
            wr_data_read = 1'b0;
            @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
        end
        push_desc(64'h8_0000_0000);
        fork
            feed(64'h8000, 16);
            tx_burst(64'h8_0000_0000, 64'h8000, 1'b0, 64'd0);
        join
        @(negedge clock);
        chk("t6_bursts", 64'(status[26:0]), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
